vram_arbiter: RTL

VRAM_ARBITER -- requirements
Module: vram_arbiter

---
 rtl/vram_arb_pkg.sv | 15 +
 rtl/vram_arb_starve_ctr.sv | 33 +++
 rtl/vram_arbiter.sv | 99 +++++++++
 3 files changed

// File: rtl/vram_arb_pkg.sv
// Shared types and default widths for the VRAM arbiter slice.
package vram_arb_pkg;

    localparam int DEFAULT_ADDR_W = 15;
    localparam int DEFAULT_DATA_W = 8;

    // Grant type taken in the previous cycle; decides where the read data goes.
    typedef enum logic [1:0] {
        OWN_NONE   = 2'd0,
        OWN_CPU_RD = 2'd1,
        OWN_CPU_WR = 2'd2,
        OWN_PPU    = 2'd3
    } vram_owner_t;

endpackage

// File: rtl/vram_arb_starve_ctr.sv
// Counts consecutive CPU stall cycles in active video; flags when the CPU must win.
module vram_arb_starve_ctr
    import vram_arb_pkg::*;
#(
    parameter int CPU_MAX_WAIT = 4
) (
    input  logic clk_pix,
    input  logic rst_n,
    input  logic line_active,
    input  logic cpu_sel,
    input  logic cpu_rdy,
    input  logic cpu_gnt,
    output logic starve
);

    localparam int                CNT_W   = $clog2(CPU_MAX_WAIT + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(CPU_MAX_WAIT);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (cpu_gnt || !line_active || !(cpu_sel && !cpu_rdy)) begin
            cnt_q <= '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign starve = (cnt_q == CNT_MAX);

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter between CPU and PPU; PPU has priority in active video.
// Optional CPU anti-starvation counter enabled by macro VRAM_ARB_ANTISTARVE_EN.
module vram_arbiter
    import vram_arb_pkg::*;
#(
    parameter int ADDR_W       = DEFAULT_ADDR_W,
    parameter int DATA_W       = DEFAULT_DATA_W,
    parameter int CPU_MAX_WAIT = 4
) (
    input  logic              clk_pix,
    input  logic              rst_n,
    input  logic              cpu_sel,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_we,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_rdy,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              ppu_req,
    input  logic [ADDR_W-1:0] ppu_addr,
    output logic              ppu_gnt,
    output logic [DATA_W-1:0] ppu_rdata,
    output logic              ppu_rvalid,
    input  logic              line_active,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    vram_owner_t       owner_q;
    vram_owner_t       owner_d;
    logic              cpu_gnt;
    logic              starve;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] ppu_rdata_q;

`ifdef VRAM_ARB_ANTISTARVE_EN
    vram_arb_starve_ctr #(
        .CPU_MAX_WAIT(CPU_MAX_WAIT)
    ) u_starve_ctr (
        .clk_pix    (clk_pix),
        .rst_n      (rst_n),
        .line_active(line_active),
        .cpu_sel    (cpu_sel),
        .cpu_rdy    (cpu_rdy),
        .cpu_gnt    (cpu_gnt),
        .starve     (starve)
    );
`else
    logic unused_max_wait;
    assign unused_max_wait = (CPU_MAX_WAIT > 0);
    assign starve          = 1'b0;
`endif

    // No grant is issued while reset is held so the RAM cannot be written.
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        cpu_gnt = 1'b0;
        ppu_gnt = 1'b0;
        owner_d = OWN_NONE;
        if (rst_n) begin
            cpu_gnt = cpu_sel && (!line_active || !ppu_req || starve);
            ppu_gnt = ppu_req && !cpu_gnt;
        end
        if (cpu_gnt) begin
            owner_d = cpu_we ? OWN_CPU_WR : OWN_CPU_RD;
        end else if (ppu_gnt) begin
            owner_d = OWN_PPU;
        end
    end

    assign cpu_rdy   = !cpu_sel || cpu_gnt;
    assign mem_addr  = ppu_gnt ? ppu_addr : cpu_addr;
    assign mem_we    = cpu_gnt && cpu_we;
    assign mem_wdata = cpu_wdata;

    always_ff @(posedge clk_pix or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so all flops update together.
        if (!rst_n) begin
            owner_q     <= OWN_NONE;
            cpu_rdata_q <= '0;
            ppu_rdata_q <= '0;
        end else begin
            owner_q <= owner_d;
            if (owner_q == OWN_CPU_RD) begin
                cpu_rdata_q <= mem_rdata;
            end
            if (owner_q == OWN_PPU) begin
                ppu_rdata_q <= mem_rdata;
            end
        end
    end

    // Return data bypasses the holding register in its valid cycle: one-cycle read latency.
    assign ppu_rvalid = (owner_q == OWN_PPU);
    assign ppu_rdata  = ppu_rvalid ? mem_rdata : ppu_rdata_q;
    assign cpu_rdata  = (owner_q == OWN_CPU_RD) ? mem_rdata : cpu_rdata_q;

endmodule
